// File: rtl/gold_sync_det.sv
// Sliding-window correlator that acquires and tracks a known Gold code period.
// Optional GOLD_SYNC_INV_EN also accepts inverted-polarity peaks and reports the polarity on inv_o.
module gold_sync_det #(
  parameter int           N        = 63,
  parameter int           LENGTH   = $clog2(N),
  parameter logic [N-1:0] REF_SEQ  = '0,
  parameter int           THRESH   = 55,
  parameter int           MISS_MAX = 2
) (
  input  logic                     clkin,
  input  logic                     rstn,
  input  logic                     chip_i,
  input  logic                     chip_valid_i,
  output logic signed [LENGTH+1:0] corr_o,
  output logic                     corr_valid_o,
  output logic                     peak_o,
  output logic                     locked_o,
  output logic [LENGTH-1:0]        phase_o,
  output logic                     inv_o
);

  typedef enum logic {S_SEARCH = 1'b0, S_LOCK = 1'b1} state_t;

  localparam logic [LENGTH:0]          C_FILL_MAX = (LENGTH+1)'(N);
  localparam logic [LENGTH-1:0]        C_PH_LAST  = LENGTH'(N-1);
  localparam logic signed [LENGTH+1:0] C_N        = (LENGTH+2)'(N);
  localparam logic signed [LENGTH+1:0] C_TH       = (LENGTH+2)'(THRESH);
  localparam logic [2:0]               C_MISS_MAX = 3'(MISS_MAX);

  function automatic logic [LENGTH:0] popcount(input logic [N-1:0] v);
    logic [LENGTH:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + {{LENGTH{1'b0}}, v[i]};
    return s;
  endfunction

  function automatic logic [LENGTH:0] fill_sat_inc(input logic [LENGTH:0] f);
    return (f == C_FILL_MAX) ? f : f + 1'b1;
  endfunction

  // Only the N-1 newest chips need storing: the oldest one is shifted out
  // on the same edge the correlation of the next window is registered.
  logic [N-2:0]              r_win_hist;
  logic [LENGTH:0]           r_fill;
  state_t                    r_state;
  logic [2:0]                r_miss;
  logic [LENGTH-1:0]         r_phase;
  logic signed [LENGTH+1:0]  r_corr;
  logic                      r_cv;
  logic                      r_peak;
  logic                      r_inv;

  logic [N-1:0]              w_win_nxt;
  logic [LENGTH:0]           w_fill_nxt;
  logic [LENGTH:0]           w_pc;
  logic signed [LENGTH+1:0]  w_corr_nxt;
  logic                      w_full;
  logic                      w_pos;
  logic                      w_neg;
  logic                      w_hit;
  state_t                    w_state_nxt;
  logic [2:0]                w_miss_nxt;
  logic [LENGTH-1:0]         w_phase_nxt;
  logic                      w_inv_nxt;
  logic                      w_peak_nxt;
  logic                      w_cv_nxt;

  assign w_win_nxt  = {r_win_hist, chip_i};
  assign w_fill_nxt = fill_sat_inc(r_fill);
  assign w_full     = (w_fill_nxt == C_FILL_MAX);
  assign w_pc       = popcount(w_win_nxt ^ REF_SEQ);
  assign w_corr_nxt = C_N - $signed({w_pc, 1'b0});
  assign w_pos      = (w_corr_nxt >= C_TH);
`ifdef GOLD_SYNC_INV_EN
  assign w_neg      = (w_corr_nxt <= -C_TH);
`else
  assign w_neg      = 1'b0;
`endif
  assign w_hit      = r_inv ? w_neg : w_pos;

  always_comb begin
    w_state_nxt = r_state;
    w_miss_nxt  = r_miss;
    w_phase_nxt = r_phase;
    w_inv_nxt   = r_inv;
    w_peak_nxt  = 1'b0;
    w_cv_nxt    = 1'b0;
    if (chip_valid_i) begin
      w_cv_nxt = w_full;
      if (r_state == S_SEARCH) begin
        if (w_full && (w_pos || w_neg)) begin
          w_state_nxt = S_LOCK;
          w_phase_nxt = '0;
          w_miss_nxt  = '0;
          w_peak_nxt  = 1'b1;
`ifdef GOLD_SYNC_INV_EN
          w_inv_nxt   = ~w_pos;
`endif
        end
      end else if (r_phase == C_PH_LAST) begin
        // Period boundary: the only chip where a peak is evaluated while locked.
        w_phase_nxt = '0;
        if (w_hit) begin
          w_peak_nxt = 1'b1;
          w_miss_nxt = '0;
        end else if (r_miss + 3'd1 >= C_MISS_MAX) begin
          w_state_nxt = S_SEARCH;
          w_miss_nxt  = '0;
        end else begin
          w_miss_nxt = r_miss + 3'd1;
        end
      end else begin
        w_phase_nxt = r_phase + 1'b1;
      end
    end
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_win_hist <= '0;
      r_fill     <= '0;
      r_state    <= S_SEARCH;
      r_miss     <= '0;
      r_phase    <= '0;
      r_corr     <= '0;
      r_cv       <= 1'b0;
      r_peak     <= 1'b0;
      r_inv      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_miss  <= w_miss_nxt;
      r_phase <= w_phase_nxt;
      r_inv   <= w_inv_nxt;
      r_peak  <= w_peak_nxt;
      r_cv    <= w_cv_nxt;
      if (chip_valid_i) begin
        r_win_hist <= w_win_nxt[N-2:0];
        r_fill     <= w_fill_nxt;
        r_corr     <= w_corr_nxt;
      end
    end
  end

  assign corr_o       = r_corr;
  assign corr_valid_o = r_cv;
  assign peak_o       = r_peak;
  assign locked_o     = (r_state == S_LOCK);
  assign phase_o      = r_phase;
  assign inv_o        = r_inv;

endmodule

// File: tb/tb_gold_sync_det.sv
// Randomized scoreboard bench for gold_sync_det; follows GOLD_SYNC_INV_EN like the design.
module tb_gold_sync_det;

  localparam int N  = 63;
  localparam int TH = 55;
  localparam int MM = 2;
  localparam logic [62:0] REF = 63'h4A3F_9C12_6E85_B7D1;
`ifdef GOLD_SYNC_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              chip_i = 1'b0;
  logic              chip_valid_i = 1'b0;
  logic signed [7:0] corr_o;
  logic              corr_valid_o, peak_o, locked_o, inv_o;
  logic [5:0]        phase_o;

  gold_sync_det #(.N(N), .REF_SEQ(REF), .THRESH(TH), .MISS_MAX(MM)) dut (
    .clkin(clk), .rstn(rstn), .chip_i(chip_i), .chip_valid_i(chip_valid_i),
    .corr_o(corr_o), .corr_valid_o(corr_valid_o), .peak_o(peak_o),
    .locked_o(locked_o), .phase_o(phase_o), .inv_o(inv_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int corr;
    bit peak;
    bit locked;
    int phase;
    bit inv;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: chip history plus chips-since-lock, in plain arithmetic.
  bit hist[$];
  bit m_locked, m_inv;
  int m_since, m_miss;

  task automatic model_reset();
    hist.delete();
    m_locked = 0; m_inv = 0; m_since = 0; m_miss = 0;
  endtask

  task automatic model_step(input bit c);
    int   corr;
    bit   pos, neg, pk;
    exp_t e;
    hist.push_back(c);
    if (hist.size() > N) void'(hist.pop_front());
    if (hist.size() != N) return;
    corr = 0;
    for (int i = 0; i < N; i++) corr += (hist[i] == REF[N-1-i]) ? 1 : -1;
    pos = (corr >= TH);
    neg = INV_EN && (corr <= -TH);
    pk  = 0;
    if (!m_locked) begin
      if (pos || neg) begin
        m_locked = 1; m_since = 0; m_miss = 0; m_inv = neg; pk = 1;
      end
    end else begin
      m_since++;
      if (m_since % N == 0) begin
        if (m_inv ? neg : pos) begin
          pk = 1; m_miss = 0;
        end else begin
          m_miss++;
          if (m_miss >= MM) begin m_locked = 0; m_miss = 0; end
        end
      end
    end
    e.corr = corr; e.peak = pk; e.locked = m_locked;
    e.phase = m_locked ? (m_since % N) : 0; e.inv = m_inv;
    q.push_back(e);
  endtask

  // Monitor: pops on every corr_valid_o; between pulses nothing may move.
  bit last_locked, last_inv;
  int last_phase;
  bit noise_on = 0;
  int noise_max = 0;
  bit noise_lock_seen = 0;
  int cv_count = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      last_locked = 0; last_phase = 0; last_inv = 0;
    end else begin
      if (noise_on && locked_o) noise_lock_seen = 1;
      if (corr_valid_o) begin
        cv_count++;
        if (noise_on) begin
          if ($signed(corr_o) > noise_max) noise_max = $signed(corr_o);
          if (-$signed(corr_o) > noise_max) noise_max = -$signed(corr_o);
        end
        if (q.size() == 0) begin
          chk("unexpected_corr_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("corr", $signed(corr_o), e.corr);
          chk("peak", peak_o, e.peak);
          chk("locked", locked_o, e.locked);
          chk("phase", phase_o, e.phase);
          chk("inv", inv_o, e.inv);
          last_locked = e.locked; last_phase = e.phase; last_inv = e.inv;
        end
      end else begin
        chk("idle_peak", peak_o, 0);
        chk("idle_locked_hold", locked_o, last_locked);
        chk("idle_phase_hold", phase_o, last_phase);
        chk("idle_inv_hold", inv_o, last_inv);
      end
    end
  end

  task automatic drive(input bit c, input int idle_pct);
    for (int k = 0; k < 8 && $urandom_range(0, 99) < idle_pct; k++) begin
      @(negedge clk);
      chip_valid_i = 1'b0;
      chip_i = 1'($urandom);
    end
    @(negedge clk);
    chip_i = c;
    chip_valid_i = 1'b1;
    model_step(c);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chip_valid_i = 1'b0;
      chip_i = 1'($urandom);
    end
  endtask

  task automatic feed_ref(input int idle_pct, input int nchips);
    for (int i = 0; i < nchips; i++) drive(REF[N-1-(i % N)], idle_pct);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_corr"}, $signed(corr_o), 0);
    chk({tag, "_corr_valid"}, corr_valid_o, 0);
    chk({tag, "_peak"}, peak_o, 0);
    chk({tag, "_locked"}, locked_o, 0);
    chk({tag, "_phase"}, phase_o, 0);
    chk({tag, "_inv"}, inv_o, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #2 rstn = 1'b1;

    // Acquisition on one clean period
    feed_ref(0, N);
    idle(1);
    chk("acq_locked", locked_o, 1);
    chk("acq_corr", $signed(corr_o), 63);
    chk("acq_phase", phase_o, 0);

    // Tracking with idle gaps
    feed_ref(30, 3 * N);
    idle(2);
    chk("track_locked", locked_o, 1);

    // Loss of lock on two all-zero periods
    for (int i = 0; i < 2 * N; i++) drive(1'b0, 0);
    idle(1);
    chk("loss_locked", locked_o, 0);
    chk("loss_phase", phase_o, 0);

    // Uncorrelated noise
    noise_on = 1;
    for (int i = 0; i < 2000; i++) drive(1'($urandom), 10);
    idle(1);
    noise_on = 0;
    chk("noise_corr_below_thresh", (noise_max < TH), 1);
    chk("noise_no_lock", noise_lock_seen, 0);

    // Inverted sequence
    for (int i = 0; i < N; i++) drive(~REF[N-1-i], 0);
    idle(1);
    chk("inv_corr", $signed(corr_o), -63);
    chk("inv_locked", locked_o, INV_EN);
    chk("inv_flag", inv_o, INV_EN);

    // Relock on the true sequence, then reset mid-lock between edges
    feed_ref(20, 4 * N);
    feed_ref(20, 20);
    idle(2);
    chk("prereset_locked", locked_o, 1);
    chk("prereset_queue_empty", q.size(), 0);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    cv_count = 0;

    feed_ref(15, N - 1);
    idle(2);
    chk("post_reset_no_cv_62", cv_count, 0);
    drive(REF[0], 0);
    idle(2);
    chk("post_reset_cv_63", cv_count, 1);
    chk("post_reset_relock", locked_o, 1);

    idle(3);
    chk("final_queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
